tx_frame_scheduler: RTL and testbench
=====================================

Name: tx_frame_scheduler

Overview:
- Sequences the TX circular-buffer read datapath. It parses each frame header, waits until the whole frame is committed, then hands frame descriptors to the MAC TX engine.
- Frees buffer space in frame order when the engine reports completion. Holds up to OUTSTANDING descriptors, so the engine can send back-to-back frames without re-parsing gaps.
- Sits between the host-side buffer writer (commited_wr_addr, already in this clock domain) and the MAC TX engine.

Parameters:
- ADDR_W, 9, buffer address width in qwords; buffer depth is 2^ADDR_W.
- LEN_W, 10, width of the payload qword count.
- OUTSTANDING, 4, maximum number of frames issued but not yet done; power of two.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- commited_wr_addr  in  ADDR_W  first unwritten qword, published by the writer.
- hdr_rd_addr  out  ADDR_W  header read address; memory returns data 1 cycle later.
- hdr_rd_data  in  64  header qword; [63:32] is the frame byte count.
- desc_valid  out  1  descriptor offered.
- desc_ready  in  1  engine accepts the descriptor.
- desc_addr  out  ADDR_W  first payload qword (header address + 1).
- desc_qwords  out  LEN_W  payload qword count.
- desc_last_valid  out  8  byte mask for the last qword.
- frame_done  in  1  one-cycle pulse; the oldest accepted frame is fully read.
- commited_rd_address  out  ADDR_W  buffer space released up to, not including, this address.
- commited_rd_address_change  out  1  one-cycle pulse when commited_rd_address updates.
- sched_err  out  1  sticky; a malformed header was seen.

Behaviour:
- Reset values: all outputs 0; internal header pointer hp = 0; FSM in IDLE.
- Decided: one clock; reset is synchronous and active-low (clk, reset_n).
- Arithmetic: all address arithmetic is modulo 2^ADDR_W. avail = commited_wr_addr - hp.
  - The writer keeps one slot empty, so avail = 0 always means empty.
- Length decode from bc = byte count:
  - desc_qwords = bc[LEN_W+2:3] + (bc[2:0] != 0).
  - desc_last_valid = 8'hFF when bc[2:0] = 0; otherwise (1 << bc[2:0]) - 1.
  - Frame footprint F = 1 + desc_qwords.
- FSM states and transitions:
  - IDLE: when avail != 0, drive hdr_rd_addr = hp and go to HDR_LAT.
  - HDR_LAT: capture hdr_rd_data into a register; go to DECODE.
  - DECODE: compute qwords, mask and F.
    - bc = 0, or bc > 8*(2^LEN_W - 1), or F > 2^ADDR_W - 1: go to ERR.
    - Otherwise go to WAIT.
  - WAIT: when avail >= F and outstanding count < OUTSTANDING, go to OFFER.
  - OFFER: hold desc_valid = 1 with stable fields until desc_ready is sampled high.
    - On acceptance: push hp + F into the release FIFO, set hp <= hp + F, go to IDLE.
    - Latency: the next header read is issued the cycle after acceptance; header to offer is at least 4 cycles.
  - ERR: set sched_err = 1; desc_valid = 0; stay in ERR until reset.
    - frame_done is still honoured so frames already accepted drain normally.
- Release path:
  - On frame_done, pop the FIFO head into commited_rd_address and pulse commited_rd_address_change in the following cycle.
  - frame_done with an empty FIFO: ignored; sched_err is set.
- Simultaneous events: acceptance and frame_done in the same cycle do both (push and pop); the outstanding count is unchanged.
- Wrap-around: frames may straddle the buffer end; desc_addr wraps naturally.
- Reset mid-operation: everything returns to reset values. A frame the engine holds at that point is abandoned; the engine must be reset together with this block.

Optional Feature:
- Macro: TX_SCHED_STATS_EN.
- With it defined:
  - Adds outputs stat_frames (32 bits) and stat_qwords (32 bits).
  - Both increment on each accepted descriptor (frames by 1, qwords by desc_qwords) and wrap at 2^32.
  - Both reset to 0.
- Without it: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package tx_sched_pkg holds:
  - FSM state encoding (IDLE, HDR_LAT, DECODE, WAIT, OFFER, ERR);
  - the header field positions (BC_MSB = 63, BC_LSB = 32);
  - the last-valid mask function.
- One sub-module: tx_sched_release_fifo.
  - Synchronous FIFO, OUTSTANDING entries of ADDR_W bits each.
  - push, pop, head, count, empty, full.
  - Read-during-write allowed when non-empty.

Test Plan:
- Single frame: header at address 0 with bc = 60, commited_wr_addr = 9 → one descriptor (addr 1, qwords 8, mask 8'h0F); after frame_done, commited_rd_address = 9 with one change pulse.
- Partial commit: bc = 64 with commited_wr_addr stepped 3 → 8 → 9 → desc_valid stays 0 until the write address reaches 9, then is asserted.
- Back-to-back with stall: four frames (bc = 8, 16, 24, 1500) and desc_ready held low for 5 cycles → descriptor fields stable during the stall; desc_qwords 1, 2, 3, 188 in order; a fifth frame is not offered until a frame_done arrives.
- Wrap: ADDR_W = 4, hp = 14, bc = 24 → desc_addr 15, qwords 3; release address (14 + 4) mod 16 = 2.
- Malformed header: bc = 0 → sched_err = 1, no descriptor issued; a pending frame_done for an earlier frame still produces a change pulse.
- Simultaneous accept and frame_done in one cycle → outstanding count unchanged; release addresses pop in FIFO order.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the TX frame scheduler: FSM encoding, header fields, length helpers.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package tx_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_LAT = 3'd1,
        DECODE  = 3'd2,
        WAIT    = 3'd3,
        OFFER   = 3'd4,
        ERR     = 3'd5
    } sched_state_t;

    // Frame byte count position inside the header qword
    localparam int BC_MSB = 63;
    localparam int BC_LSB = 32;

    // Byte-valid mask for the final payload qword given byte_count[2:0]
    function automatic logic [7:0] last_valid_mask(input logic [2:0] rem);
        logic [7:0] m;
        if (rem == 3'd0) begin
            m = 8'hFF;
        end else begin
            m = (8'd1 << rem) - 8'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tx_sched_release_fifo.sv
// Release-address FIFO: holds end-of-frame addresses of frames issued to the MAC but not yet done.
// Latency: head is valid combinationally from storage; push/pop take effect on the next clock.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module tx_sched_release_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [W-1:0] r_mem [DEPTH];
    ptr_t         r_wr_ptr;
    ptr_t         r_rd_ptr;
    cnt_t         r_count;

    logic w_do_push;
    logic w_do_pop;

    // A pop frees a slot in the same cycle, so push into a full FIFO is legal alongside a pop
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != cnt_t'(DEPTH)) || w_do_pop);

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == cnt_t'(DEPTH));

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// TX read-side scheduler: parses frame headers, waits for full commit, issues descriptors, releases space in order.
// Latency: header read to desc_valid is 4 cycles; next header read starts the cycle after acceptance.
// Backpressure: desc_valid/desc_ready handshake; at most OUTSTANDING frames in flight. TX_SCHED_STATS_EN adds counters.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int LEN_W       = 10,
    parameter int OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] commited_wr_addr,
    output logic [ADDR_W-1:0] hdr_rd_addr,
    input  logic [63:0]       hdr_rd_data,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [ADDR_W-1:0] desc_addr,
    output logic [LEN_W-1:0]  desc_qwords,
    output logic [7:0]        desc_last_valid,
    input  logic              frame_done,
    output logic [ADDR_W-1:0] commited_rd_address,
    output logic              commited_rd_address_change,
    output logic              sched_err
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_frames,
    output logic [31:0]       stat_qwords
`endif
);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LEN_W-1:0]  len_t;

    // Largest legal byte count and largest footprint that fits with one slot kept empty
    localparam logic [31:0] MAX_BC   = 32'(8 * ((1 << LEN_W) - 1));
    localparam logic [31:0] MAX_FOOT = 32'((1 << ADDR_W) - 1);

    sched_state_t r_state;
    addr_t        r_hp;
    logic [31:0]  r_bc;
    len_t         r_qwords;
    logic [7:0]   r_mask;
    addr_t        r_foot;
    addr_t        r_desc_addr;
    logic         r_desc_valid;
    addr_t        r_rd_addr;
    logic         r_rd_change;
    logic         r_err;

    addr_t                    w_avail;
    logic [LEN_W:0]           w_qw_full;
    logic [LEN_W+1:0]         w_foot_full;
    logic                     w_hdr_bad;
    logic                     w_accept;
    addr_t                    w_next_hp;
    logic                     w_push;
    logic                     w_pop;
    addr_t                    w_fifo_head;
    logic [$clog2(OUTSTANDING):0] w_fifo_count;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic                     w_unused_hdr_bits;

    // Only the byte-count half of the header carries information for this block
    assign w_unused_hdr_bits = &{1'b0, hdr_rd_data[BC_LSB-1:0]};

    // Committed-but-unparsed qwords; zero always means empty since the writer keeps a slot free
    assign w_avail = commited_wr_addr - r_hp;

    // Round the byte count up to whole qwords; footprint adds the header qword
    assign w_qw_full   = {1'b0, r_bc[LEN_W+2:3]} + {{LEN_W{1'b0}}, (r_bc[2:0] != 3'd0)};
    assign w_foot_full = {1'b0, w_qw_full} + {{(LEN_W+1){1'b0}}, 1'b1};
    assign w_hdr_bad   = (r_bc == 32'd0) || (r_bc > MAX_BC) || (32'(w_foot_full) > MAX_FOOT);

    assign w_accept  = (r_state == OFFER) && r_desc_valid && desc_ready;
    assign w_next_hp = r_hp + r_foot;
    assign w_pop     = frame_done && !w_fifo_empty;
    assign w_push    = w_accept && (!w_fifo_full || w_pop);

    tx_sched_release_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (ADDR_W)
    ) u_release_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (w_push),
        .push_dat (w_next_hp),
        .pop      (w_pop),
        .head     (w_fifo_head),
        .count    (w_fifo_count),
        .empty    (w_fifo_empty),
        .full     (w_fifo_full)
    );

    // Header parse / descriptor issue FSM with registered descriptor outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_hp         <= '0;
            r_bc         <= '0;
            r_qwords     <= '0;
            r_mask       <= '0;
            r_foot       <= '0;
            r_desc_addr  <= '0;
            r_desc_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_avail != '0) begin
                        r_state <= HDR_LAT;
                    end
                end
                HDR_LAT: begin
                    r_bc    <= hdr_rd_data[BC_MSB:BC_LSB];
                    r_state <= DECODE;
                end
                DECODE: begin
                    if (w_hdr_bad) begin
                        r_state <= ERR;
                    end else begin
                        r_qwords    <= len_t'(w_qw_full);
                        r_mask      <= last_valid_mask(r_bc[2:0]);
                        r_foot      <= addr_t'(w_foot_full);
                        r_desc_addr <= r_hp + addr_t'(1);
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if ((w_avail >= r_foot) && (32'(w_fifo_count) < 32'(OUTSTANDING))) begin
                        r_desc_valid <= 1'b1;
                        r_state      <= OFFER;
                    end
                end
                OFFER: begin
                    if (w_accept) begin
                        r_desc_valid <= 1'b0;
                        r_hp         <= w_next_hp;
                        r_state      <= IDLE;
                    end
                end
                ERR: begin
                    r_desc_valid <= 1'b0;
                end
                default: begin
                    r_desc_valid <= 1'b0;
                    r_state      <= ERR;
                end
            endcase
        end
    end

    // In-order space release on frame_done, plus sticky error capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_addr   <= '0;
            r_rd_change <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rd_change <= 1'b0;
            if (w_pop) begin
                r_rd_addr   <= w_fifo_head;
                r_rd_change <= 1'b1;
            end
            if ((frame_done && w_fifo_empty) || ((r_state == DECODE) && w_hdr_bad)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef TX_SCHED_STATS_EN
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_qwords;

    // Free-running accepted-frame and payload-qword counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_frames <= '0;
            r_stat_qwords <= '0;
        end else if (w_accept) begin
            r_stat_frames <= r_stat_frames + 32'd1;
            r_stat_qwords <= r_stat_qwords + 32'(r_qwords);
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_qwords = r_stat_qwords;
`endif

    assign hdr_rd_addr                = r_hp;
    assign desc_valid                 = r_desc_valid;
    assign desc_addr                  = r_desc_addr;
    assign desc_qwords                = r_qwords;
    assign desc_last_valid            = r_mask;
    assign commited_rd_address        = r_rd_addr;
    assign commited_rd_address_change = r_rd_change;
    assign sched_err                  = r_err;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: default-size instance plus a 4-bit-address instance for wrap.
// Latency: header memory model returns data one cycle after the address.
// Backpressure: desc_ready driven by the directed steps.
module tb_tx_frame_scheduler;

    localparam int AW  = 9;
    localparam int LW  = 10;
    localparam int AWB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance A (default parameters)
    logic [AW-1:0] wr_a, hdr_addr_a, desc_addr_a, rd_addr_a;
    logic [63:0]   hdr_data_a;
    logic          vld_a, rdy_a, done_a, chg_a, err_a;
    logic [LW-1:0] qw_a;
    logic [7:0]    mask_a;
    logic [63:0]   mem_a [1 << AW];

    // Instance B (ADDR_W = 4)
    logic [AWB-1:0] wr_b, hdr_addr_b, desc_addr_b, rd_addr_b;
    logic [63:0]    hdr_data_b;
    logic           vld_b, rdy_b, done_b, chg_b, err_b;
    logic [LW-1:0]  qw_b;
    logic [7:0]     mask_b;
    logic [63:0]    mem_b [1 << AWB];

`ifdef TX_SCHED_STATS_EN
    logic [31:0] sf_a, sq_a, sf_b, sq_b;
`endif

    always @(posedge clk) hdr_data_a <= mem_a[hdr_addr_a];
    always @(posedge clk) hdr_data_b <= mem_b[hdr_addr_b];

    tx_frame_scheduler #(.ADDR_W(AW), .LEN_W(LW), .OUTSTANDING(4)) dut_a (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .commited_wr_addr           (wr_a),
        .hdr_rd_addr                (hdr_addr_a),
        .hdr_rd_data                (hdr_data_a),
        .desc_valid                 (vld_a),
        .desc_ready                 (rdy_a),
        .desc_addr                  (desc_addr_a),
        .desc_qwords                (qw_a),
        .desc_last_valid            (mask_a),
        .frame_done                 (done_a),
        .commited_rd_address        (rd_addr_a),
        .commited_rd_address_change (chg_a),
        .sched_err                  (err_a)
`ifdef TX_SCHED_STATS_EN
        ,
        .stat_frames                (sf_a),
        .stat_qwords                (sq_a)
`endif
    );

    tx_frame_scheduler #(.ADDR_W(AWB), .LEN_W(LW), .OUTSTANDING(4)) dut_b (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .commited_wr_addr           (wr_b),
        .hdr_rd_addr                (hdr_addr_b),
        .hdr_rd_data                (hdr_data_b),
        .desc_valid                 (vld_b),
        .desc_ready                 (rdy_b),
        .desc_addr                  (desc_addr_b),
        .desc_qwords                (qw_b),
        .desc_last_valid            (mask_b),
        .frame_done                 (done_b),
        .commited_rd_address        (rd_addr_b),
        .commited_rd_address_change (chg_b),
        .sched_err                  (err_b)
`ifdef TX_SCHED_STATS_EN
        ,
        .stat_frames                (sf_b),
        .stat_qwords                (sq_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_a = '0; rdy_a = 1'b0; done_a = 1'b0;
        wr_b = '0; rdy_b = 1'b0; done_b = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem_a[i] = 64'd0;
        for (int i = 0; i < (1 << AWB); i++) mem_b[i] = 64'd0;
        tick(3);
        reset_n = 1'b1;
    endtask

    // Bounded wait for an offer; timing out counts as a failed comparison
    task automatic wait_vld(input string tag, input bit use_b, input int max);
        int k;
        k = 0;
        while (!(use_b ? vld_b : vld_a) && k < max) begin
            tick(1);
            k++;
        end
        chk(tag, use_b ? vld_b : vld_a, 1);
    endtask

    task automatic accept_a();
        rdy_a = 1'b1; tick(1); rdy_a = 1'b0;
    endtask

    task automatic pulse_done_a();
        done_a = 1'b1; tick(1); done_a = 1'b0;
    endtask

    // Watch for any offer over n cycles
    task automatic watch_a(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (vld_a) seen = 1'b1;
        end
    endtask

    bit seen;

    initial begin
        // ---- Reset state ----
        do_reset();
        reset_n = 1'b0;
        tick(1);
        chk("rst_desc_valid", vld_a, 0);
        chk("rst_rd_addr", rd_addr_a, 0);
        chk("rst_change", chg_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_hdr_addr", hdr_addr_a, 0);

        // ---- Single frame: bc=60 at 0, commit 9 ----
        do_reset();
        mem_a[0] = {32'd60, 32'd0};
        wr_a = 9'd9;
        tick(3);
        chk("single_not_yet", vld_a, 0);
        tick(1);
        chk("single_offer_lat4", vld_a, 1);
        chk("single_addr", desc_addr_a, 1);
        chk("single_qwords", qw_a, 8);
        chk("single_mask", mask_a, 8'h0F);
        accept_a();
        chk("single_vld_drop", vld_a, 0);
        chk("single_next_hdr", hdr_addr_a, 9);
        pulse_done_a();
        chk("single_rel_addr", rd_addr_a, 9);
        chk("single_chg_pulse", chg_a, 1);
        tick(1);
        chk("single_chg_clear", chg_a, 0);

        // ---- Partial commit: bc=64, commit 3 -> 8 -> 9 ----
        do_reset();
        mem_a[0] = {32'd64, 32'd0};
        wr_a = 9'd3;
        tick(8);
        chk("partial_wr3", vld_a, 0);
        wr_a = 9'd8;
        tick(4);
        chk("partial_wr8", vld_a, 0);
        wr_a = 9'd9;
        tick(1);
        chk("partial_wr9", vld_a, 1);
        chk("partial_qwords", qw_a, 8);
        chk("partial_mask", mask_a, 8'hFF);

        // ---- Back-to-back with stall, outstanding limit, simultaneous accept+done ----
        do_reset();
        mem_a[0]   = {32'd8, 32'd0};
        mem_a[2]   = {32'd16, 32'd0};
        mem_a[5]   = {32'd24, 32'd0};
        mem_a[9]   = {32'd1500, 32'd0};
        mem_a[198] = {32'd8, 32'd0};
        mem_a[200] = {32'd8, 32'd0};
        mem_a[202] = {32'd8, 32'd0};
        wr_a = 9'd204;
        wait_vld("b2b_f1_offer", 1'b0, 20);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("b2b_stall_vld", vld_a, 1);
            chk("b2b_stall_qw", qw_a, 1);
            chk("b2b_stall_addr", desc_addr_a, 1);
        end
        accept_a();
        wait_vld("b2b_f2_offer", 1'b0, 20);
        chk("b2b_f2_qw", qw_a, 2);
        chk("b2b_f2_addr", desc_addr_a, 3);
        accept_a();
        wait_vld("b2b_f3_offer", 1'b0, 20);
        chk("b2b_f3_qw", qw_a, 3);
        chk("b2b_f3_addr", desc_addr_a, 6);
        accept_a();
        wait_vld("b2b_f4_offer", 1'b0, 20);
        chk("b2b_f4_qw", qw_a, 188);
        chk("b2b_f4_addr", desc_addr_a, 10);
        chk("b2b_f4_mask", mask_a, 8'h0F);
        accept_a();
        watch_a(20, seen);
        chk("b2b_f5_blocked", seen, 0);
        pulse_done_a();
        chk("b2b_rel1", rd_addr_a, 2);
        chk("b2b_rel1_chg", chg_a, 1);
        wait_vld("b2b_f5_offer", 1'b0, 20);
        chk("b2b_f5_addr", desc_addr_a, 199);
        chk("b2b_f5_qw", qw_a, 1);
        // accept frame 5 and retire frame 2 in the same cycle
        rdy_a = 1'b1; done_a = 1'b1;
        tick(1);
        rdy_a = 1'b0; done_a = 1'b0;
        chk("sim_rel2", rd_addr_a, 5);
        chk("sim_rel2_chg", chg_a, 1);
        chk("sim_vld_drop", vld_a, 0);
        wait_vld("sim_f6_offer", 1'b0, 20);
        chk("sim_f6_addr", desc_addr_a, 201);
        accept_a();
        watch_a(20, seen);
        chk("sim_f7_blocked", seen, 0);
        pulse_done_a();
        chk("drain_rel3", rd_addr_a, 9);
        tick(1);
        pulse_done_a();
        chk("drain_rel4", rd_addr_a, 198);
        tick(1);
        pulse_done_a();
        chk("drain_rel5", rd_addr_a, 200);
        tick(1);
        pulse_done_a();
        chk("drain_rel6", rd_addr_a, 202);
        chk("drain_err_clear", err_a, 0);
        wait_vld("drain_f7_offer", 1'b0, 20);
        chk("drain_f7_addr", desc_addr_a, 203);
        tick(1);
        pulse_done_a();
        chk("empty_done_err", err_a, 1);
        chk("empty_done_no_chg", chg_a, 0);
        chk("empty_done_addr", rd_addr_a, 202);

        // ---- Malformed header bc=0 after a good frame ----
        do_reset();
        mem_a[0] = {32'd24, 32'd0};
        mem_a[4] = {32'd0, 32'd0};
        wr_a = 9'd10;
        wait_vld("mal_f1_offer", 1'b0, 20);
        chk("mal_f1_qw", qw_a, 3);
        chk("mal_f1_mask", mask_a, 8'hFF);
        accept_a();
        watch_a(8, seen);
        chk("mal_no_offer", seen, 0);
        chk("mal_err", err_a, 1);
        pulse_done_a();
        chk("mal_rel", rd_addr_a, 4);
        chk("mal_rel_chg", chg_a, 1);
        chk("mal_err_sticky", err_a, 1);

        // ---- Oversized byte count and oversized footprint ----
        do_reset();
        mem_a[0] = {32'd8185, 32'd0};
        wr_a = 9'd100;
        tick(8);
        chk("big_bc_err", err_a, 1);
        chk("big_bc_no_offer", vld_a, 0);
        do_reset();
        mem_a[0] = {32'd4088, 32'd0};
        wr_a = 9'd511;
        tick(8);
        chk("big_foot_err", err_a, 1);
        // largest footprint that still fits
        do_reset();
        mem_a[0] = {32'd4080, 32'd0};
        wr_a = 9'd511;
        wait_vld("max_foot_offer", 1'b0, 20);
        chk("max_foot_qw", qw_a, 510);
        chk("max_foot_err", err_a, 0);

        // ---- Wrap on 16-qword buffer: hp=14, bc=24 ----
        do_reset();
        mem_b[0] = {32'd104, 32'd0};
        wr_b = 4'd14;
        wait_vld("wrap_f1_offer", 1'b1, 20);
        chk("wrap_f1_qw", qw_b, 13);
        rdy_b = 1'b1; tick(1); rdy_b = 1'b0;
        done_b = 1'b1; tick(1); done_b = 1'b0;
        chk("wrap_rel1", rd_addr_b, 14);
        mem_b[14] = {32'd24, 32'd0};
        wr_b = 4'd2;
        wait_vld("wrap_f2_offer", 1'b1, 20);
        chk("wrap_addr", desc_addr_b, 15);
        chk("wrap_qw", qw_b, 3);
        chk("wrap_mask", mask_b, 8'hFF);
        rdy_b = 1'b1; tick(1); rdy_b = 1'b0;
        done_b = 1'b1; tick(1); done_b = 1'b0;
        chk("wrap_rel2", rd_addr_b, 2);
        chk("wrap_rel2_chg", chg_b, 1);
        chk("wrap_err", err_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
